// File: rtl/game_pkg.sv
// Shared types and helpers for the game round controller.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    INTRO      = 3'd1,
    PLAY       = 3'd2,
    PAUSE      = 3'd3,
    ROUND_DONE = 3'd4,
    WIN        = 3'd5,
    LOSE       = 3'd6
  } game_state_t;

  // Unsigned add clamped to max_val; widths up to 32 bits.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] max_val);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, max_val}) ? max_val : sum[31:0];
  endfunction

endpackage

// File: rtl/game_round_ctrl_if.sv
// Event inputs and status outputs between game logic and the round controller.
interface game_round_ctrl_if #(
  parameter int unsigned ROUND_W = 4,
  parameter int unsigned TIMER_W = 12,
  parameter int unsigned SCORE_W = 16
);
  import game_pkg::*;

  logic               start;
  logic               frame_tick;
  logic               pause_req;
  logic               round_clear;
  logic               player_dead;
  game_state_t        state_o;
  logic [ROUND_W-1:0] round_o;
  logic [TIMER_W-1:0] time_left;
  logic [SCORE_W-1:0] score;
  logic               show_banner;
  logic               play_active;
  logic               round_start;
  logic               game_over;
  logic               game_won;

  modport master (
    output start, frame_tick, pause_req, round_clear, player_dead,
    input  state_o, round_o, time_left, score, show_banner, play_active,
           round_start, game_over, game_won
  );

  modport slave (
    input  start, frame_tick, pause_req, round_clear, player_dead,
    output state_o, round_o, time_left, score, show_banner, play_active,
           round_start, game_over, game_won
  );

endinterface

// File: rtl/frame_countdown.sv
// Loadable frame down-counter that stops at zero; flags the last count.
module frame_countdown #(
  parameter int unsigned W = 12
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic [W-1:0] o_count,
  output logic         o_last_c
);

  logic [W-1:0] r_count;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_count  = r_count;
  assign o_last_c = (r_count == W'(1));

endmodule

// File: rtl/game_round_ctrl.sv
// N-round game sequencer: intro banner, timed play with pause, scoring, win/lose.
module game_round_ctrl
  import game_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS   = 3,
  parameter int unsigned ROUND_W      = 4,
  parameter int unsigned TIMER_W      = 12,
  parameter int unsigned ROUND_FRAMES = 1800,
  parameter int unsigned INTRO_FRAMES = 120,
  parameter int unsigned SCORE_W      = 16,
  parameter int unsigned ROUND_BONUS  = 100
) (
  input  logic              CLK,
  input  logic              RESET,
  game_round_ctrl_if.slave  bus
);

  localparam int unsigned INTRO_W = (INTRO_FRAMES < 2) ? 1 : $clog2(INTRO_FRAMES + 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  game_state_t        r_state;
  game_state_t        w_next_state;
  logic [ROUND_W-1:0] r_round;
  logic [SCORE_W-1:0] r_score;
  logic               r_show_banner;
  logic               r_play_active;
  logic               r_round_start;
  logic               r_game_over;
  logic               r_game_won;

  logic               w_new_game;
  logic               w_round_inc;
  logic               w_intro_en;
  logic               w_intro_last;
  logic               w_timer_load;
  logic               w_timer_en;
  logic               w_timer_last;
  logic               w_score_add;
  logic               w_round_start;
  logic [TIMER_W-1:0] w_time_left;
  logic [INTRO_W-1:0] w_intro_count;

  frame_countdown #(.W(INTRO_W)) u_intro_cnt (
    .CLK        (CLK),
    .RESET      (RESET),
    .i_load     (w_new_game | w_round_inc),
    .i_load_val (INTRO_W'(INTRO_FRAMES)),
    .i_en       (w_intro_en),
    .o_count    (w_intro_count),
    .o_last_c   (w_intro_last)
  );

  frame_countdown #(.W(TIMER_W)) u_round_timer (
    .CLK        (CLK),
    .RESET      (RESET),
    .i_load     (w_timer_load),
    .i_load_val (TIMER_W'(ROUND_FRAMES)),
    .i_en       (w_timer_en),
    .o_count    (w_time_left),
    .o_last_c   (w_timer_last)
  );

  always_ff @(posedge CLK) begin
    if (RESET) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Next state and datapath strobes; PLAY events resolved in priority order.
  always_comb begin
    w_next_state  = r_state;
    w_new_game    = 1'b0;
    w_round_inc   = 1'b0;
    w_intro_en    = 1'b0;
    w_timer_load  = 1'b0;
    w_timer_en    = 1'b0;
    w_score_add   = 1'b0;
    w_round_start = 1'b0;
    unique case (r_state)
      IDLE, WIN, LOSE: begin
        if (bus.start) begin
          w_next_state = INTRO;
          w_new_game   = 1'b1;
        end
      end
      INTRO: begin
        w_intro_en = bus.frame_tick;
        if (bus.frame_tick && w_intro_last) begin
          w_next_state  = PLAY;
          w_timer_load  = 1'b1;
          w_round_start = 1'b1;
        end
      end
      PLAY: begin
        if (bus.player_dead) begin
          w_next_state = LOSE;
        end else if (bus.round_clear) begin
          w_score_add  = 1'b1;
          w_next_state = (r_round == ROUND_W'(NUM_ROUNDS)) ? WIN : ROUND_DONE;
        end else if (bus.frame_tick && w_timer_last) begin
          w_timer_en   = 1'b1;
          w_next_state = LOSE;
        end else if (bus.pause_req) begin
          w_next_state = PAUSE;
        end else if (bus.frame_tick) begin
          w_timer_en = 1'b1;
        end
      end
      PAUSE: begin
        if (bus.pause_req) w_next_state = PLAY;
      end
      ROUND_DONE: begin
        w_round_inc  = 1'b1;
        w_next_state = INTRO;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Round index, score and status flags, all registered.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_round       <= '0;
      r_score       <= '0;
      r_show_banner <= 1'b0;
      r_play_active <= 1'b0;
      r_round_start <= 1'b0;
      r_game_over   <= 1'b0;
      r_game_won    <= 1'b0;
    end else begin
      if (w_new_game)       r_round <= ROUND_W'(1);
      else if (w_round_inc) r_round <= r_round + ROUND_W'(1);

      if (w_new_game) begin
        r_score <= '0;
      end else if (w_score_add) begin
        r_score <= SCORE_W'(sat_add(32'(r_score),
                                    32'(w_time_left) + 32'(ROUND_BONUS),
                                    32'(SCORE_MAX)));
      end

      r_show_banner <= (w_next_state == INTRO);
      r_play_active <= (w_next_state == PLAY);
      r_round_start <= w_round_start;
      r_game_over   <= (w_next_state == WIN) || (w_next_state == LOSE);
      r_game_won    <= (w_next_state == WIN);
    end
  end

  assign bus.state_o     = r_state;
  assign bus.round_o     = r_round;
  assign bus.time_left   = w_time_left;
  assign bus.score       = r_score;
  assign bus.show_banner = r_show_banner;
  assign bus.play_active = r_play_active;
  assign bus.round_start = r_round_start;
  assign bus.game_over   = r_game_over;
  assign bus.game_won    = r_game_won;

endmodule

// File: tb/tb_game_round_ctrl.sv
// Directed scenarios plus randomized events against a rule-level model of the game flow.
module tb_game_round_ctrl;
  import game_pkg::*;

  localparam int unsigned NR    = 3;
  localparam int unsigned RF    = 5;
  localparam int unsigned IF_N  = 2;
  localparam int unsigned BONUS = 100;
  localparam int unsigned SMAX  = 65535;

  logic CLK = 1'b0;
  logic RESET;
  int   checks = 0;
  int   errors = 0;

  game_round_ctrl_if #(.ROUND_W(4), .TIMER_W(12), .SCORE_W(16)) bus();

  game_round_ctrl #(
    .NUM_ROUNDS(NR), .ROUND_W(4), .TIMER_W(12), .ROUND_FRAMES(RF),
    .INTRO_FRAMES(IF_N), .SCORE_W(16), .ROUND_BONUS(BONUS)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  // Rule-level model of the game
  game_state_t m_st = IDLE;
  int m_round = 0, m_time = 0, m_score = 0, m_intro = 0;
  bit m_rs = 0;

  function automatic void model_step(input bit s, ft, pr, rc, pd, rst);
    m_rs = 0;
    if (rst) begin
      m_st = IDLE; m_round = 0; m_time = 0; m_score = 0; m_intro = 0;
      return;
    end
    case (m_st)
      IDLE, WIN, LOSE:
        if (s) begin m_st = INTRO; m_round = 1; m_score = 0; m_intro = IF_N; end
      INTRO:
        if (ft) begin
          if (m_intro == 1) begin m_st = PLAY; m_time = RF; m_rs = 1; end
          if (m_intro > 0) m_intro--;
        end
      PLAY:
        if (pd) m_st = LOSE;
        else if (rc) begin
          m_score = (m_score + m_time + BONUS > SMAX) ? SMAX : m_score + m_time + BONUS;
          m_st = (m_round == NR) ? WIN : ROUND_DONE;
        end
        else if (ft && m_time == 1) begin m_time = 0; m_st = LOSE; end
        else if (pr) m_st = PAUSE;
        else if (ft && m_time > 0) m_time--;
      PAUSE: if (pr) m_st = PLAY;
      ROUND_DONE: begin m_round++; m_intro = IF_N; m_st = INTRO; end
      default: m_st = IDLE;
    endcase
  endfunction

  task automatic cyc(input bit s = 0, ft = 0, pr = 0, rc = 0, pd = 0, rst = 0);
    RESET = rst; bus.start = s; bus.frame_tick = ft; bus.pause_req = pr;
    bus.round_clear = rc; bus.player_dead = pd;
    @(posedge CLK);
    model_step(s, ft, pr, rc, pd, rst);
    #1;
  endtask

  task automatic test_reset;
    cyc(.rst(1)); cyc(.rst(1));
    checks++; if (bus.state_o !== IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", bus.state_o, IDLE); end
    checks++; if (bus.round_o !== 4'd0) begin errors++; $display("FAIL reset_round got=%0d exp=0", bus.round_o); end
    checks++; if (bus.time_left !== 12'd0 || bus.score !== 16'd0) begin errors++; $display("FAIL reset_time_score got=%0d/%0d exp=0/0", bus.time_left, bus.score); end
    checks++; if ({bus.show_banner, bus.play_active, bus.round_start, bus.game_over, bus.game_won} !== 5'b0) begin
      errors++; $display("FAIL reset_flags got=%b exp=00000", {bus.show_banner, bus.play_active, bus.round_start, bus.game_over, bus.game_won}); end
  endtask

  task automatic test_first_round;
    cyc(.s(1));
    checks++; if (bus.state_o !== INTRO || bus.round_o !== 4'd1 || bus.show_banner !== 1'b1) begin
      errors++; $display("FAIL start_intro got st=%0d rnd=%0d ban=%b exp st=1 rnd=1 ban=1", bus.state_o, bus.round_o, bus.show_banner); end
    cyc(.ft(1));
    checks++; if (bus.state_o !== INTRO || bus.round_start !== 1'b0) begin
      errors++; $display("FAIL intro_hold got st=%0d rs=%b exp st=1 rs=0", bus.state_o, bus.round_start); end
    cyc(.ft(1));
    checks++; if (bus.state_o !== PLAY || bus.round_start !== 1'b1 || bus.time_left !== 12'd5) begin
      errors++; $display("FAIL intro_to_play got st=%0d rs=%b tl=%0d exp st=2 rs=1 tl=5", bus.state_o, bus.round_start, bus.time_left); end
    checks++; if (bus.play_active !== 1'b1 || bus.show_banner !== 1'b0 || bus.round_o !== 4'd1) begin
      errors++; $display("FAIL play_flags got pa=%b ban=%b rnd=%0d exp pa=1 ban=0 rnd=1", bus.play_active, bus.show_banner, bus.round_o); end
    cyc();
    checks++; if (bus.round_start !== 1'b0 || bus.time_left !== 12'd5) begin
      errors++; $display("FAIL round_start_pulse got rs=%b tl=%0d exp rs=0 tl=5", bus.round_start, bus.time_left); end
  endtask

  task automatic test_round_clear;
    cyc(.ft(1)); cyc(.ft(1));
    checks++; if (bus.time_left !== 12'd3) begin errors++; $display("FAIL play_count got=%0d exp=3", bus.time_left); end
    cyc(.rc(1));
    checks++; if (bus.score !== 16'd103 || bus.state_o !== ROUND_DONE) begin
      errors++; $display("FAIL clear_score got sc=%0d st=%0d exp sc=103 st=4", bus.score, bus.state_o); end
    cyc();
    checks++; if (bus.state_o !== INTRO || bus.round_o !== 4'd2) begin
      errors++; $display("FAIL next_round got st=%0d rnd=%0d exp st=1 rnd=2", bus.state_o, bus.round_o); end
  endtask

  task automatic test_win;
    cyc(.rst(1)); cyc(.s(1));
    for (int r = 1; r <= 3; r++) begin
      cyc(.ft(1)); cyc(.ft(1));
      checks++; if (bus.state_o !== PLAY || bus.round_o !== 4'(r)) begin
        errors++; $display("FAIL win_play_r%0d got st=%0d rnd=%0d exp st=2 rnd=%0d", r, bus.state_o, bus.round_o, r); end
      cyc(.rc(1));
      if (r < 3) cyc();
    end
    checks++; if (bus.state_o !== WIN || bus.score !== 16'd315) begin
      errors++; $display("FAIL win_state got st=%0d sc=%0d exp st=5 sc=315", bus.state_o, bus.score); end
    checks++; if (bus.game_won !== 1'b1 || bus.game_over !== 1'b1 || bus.round_o !== 4'd3) begin
      errors++; $display("FAIL win_flags got gw=%b go=%b rnd=%0d exp 1 1 3", bus.game_won, bus.game_over, bus.round_o); end
    cyc(.ft(1), .rc(1), .pr(1));
    checks++; if (bus.state_o !== WIN || bus.score !== 16'd315) begin
      errors++; $display("FAIL win_hold got st=%0d sc=%0d exp st=5 sc=315", bus.state_o, bus.score); end
    cyc(.s(1));
    checks++; if (bus.state_o !== INTRO || bus.round_o !== 4'd1 || bus.score !== 16'd0 || bus.game_over !== 1'b0) begin
      errors++; $display("FAIL restart got st=%0d rnd=%0d sc=%0d go=%b exp 1 1 0 0", bus.state_o, bus.round_o, bus.score, bus.game_over); end
  endtask

  task automatic test_timeout;
    cyc(.ft(1)); cyc(.ft(1));
    for (int i = 0; i < 4; i++) cyc(.ft(1));
    checks++; if (bus.state_o !== PLAY || bus.time_left !== 12'd1) begin
      errors++; $display("FAIL timeout_pre got st=%0d tl=%0d exp st=2 tl=1", bus.state_o, bus.time_left); end
    cyc(.ft(1));
    checks++; if (bus.state_o !== LOSE || bus.time_left !== 12'd0 || bus.game_won !== 1'b0 || bus.game_over !== 1'b1) begin
      errors++; $display("FAIL timeout_lose got st=%0d tl=%0d gw=%b go=%b exp 6 0 0 1", bus.state_o, bus.time_left, bus.game_won, bus.game_over); end
    cyc(.ft(1));
    checks++; if (bus.time_left !== 12'd0 || bus.state_o !== LOSE) begin
      errors++; $display("FAIL no_underflow got st=%0d tl=%0d exp 6 0", bus.state_o, bus.time_left); end
    cyc(.s(1)); cyc(.ft(1)); cyc(.ft(1));
    for (int i = 0; i < 4; i++) cyc(.ft(1));
    cyc(.ft(1), .rc(1));
    checks++; if (bus.score !== 16'd101 || bus.state_o !== ROUND_DONE) begin
      errors++; $display("FAIL last_tick_clear got sc=%0d st=%0d exp sc=101 st=4", bus.score, bus.state_o); end
    cyc();
  endtask

  task automatic test_pause;
    cyc(.ft(1)); cyc(.ft(1)); cyc(.ft(1));
    cyc(.pr(1), .ft(1));
    checks++; if (bus.state_o !== PAUSE || bus.time_left !== 12'd4) begin
      errors++; $display("FAIL pause_enter got st=%0d tl=%0d exp st=3 tl=4", bus.state_o, bus.time_left); end
    for (int i = 0; i < 10; i++) cyc(.ft(1), .rc(i == 3), .pd(i == 6));
    checks++; if (bus.state_o !== PAUSE || bus.time_left !== 12'd4 || bus.score !== 16'd101) begin
      errors++; $display("FAIL pause_frozen got st=%0d tl=%0d sc=%0d exp 3 4 101", bus.state_o, bus.time_left, bus.score); end
    cyc(.pr(1));
    checks++; if (bus.state_o !== PLAY || bus.time_left !== 12'd4) begin
      errors++; $display("FAIL pause_exit got st=%0d tl=%0d exp st=2 tl=4", bus.state_o, bus.time_left); end
    cyc(.ft(1));
    checks++; if (bus.time_left !== 12'd3) begin errors++; $display("FAIL pause_resume got=%0d exp=3", bus.time_left); end
  endtask

  task automatic test_reset_mid_play;
    cyc(.rst(1)); cyc(.s(1)); cyc(.ft(1)); cyc(.ft(1)); cyc(.ft(1)); cyc(.ft(1));
    cyc(.rc(1)); cyc(); cyc(.ft(1)); cyc(.ft(1));
    checks++; if (bus.state_o !== PLAY || bus.round_o !== 4'd2 || bus.score !== 16'd103) begin
      errors++; $display("FAIL mid_setup got st=%0d rnd=%0d sc=%0d exp 2 2 103", bus.state_o, bus.round_o, bus.score); end
    cyc(.rst(1), .rc(1));
    checks++; if (bus.state_o !== IDLE || bus.round_o !== 4'd0 || bus.score !== 16'd0 || bus.time_left !== 12'd0) begin
      errors++; $display("FAIL mid_reset got st=%0d rnd=%0d sc=%0d tl=%0d exp 0 0 0 0", bus.state_o, bus.round_o, bus.score, bus.time_left); end
    cyc(.s(1)); cyc(.ft(1)); cyc(.ft(1));
    cyc(.rc(1), .pd(1));
    checks++; if (bus.state_o !== LOSE || bus.score !== 16'd0) begin
      errors++; $display("FAIL dead_beats_clear got st=%0d sc=%0d exp st=6 sc=0", bus.state_o, bus.score); end
  endtask

  task automatic test_random;
    logic [4:0] exp_f, got_f;
    for (int i = 0; i < 4000; i++) begin
      cyc(.s($urandom_range(7) == 0), .ft($urandom_range(1) == 1), .pr($urandom_range(15) == 0),
          .rc($urandom_range(15) == 0), .pd($urandom_range(31) == 0), .rst($urandom_range(299) == 0));
      exp_f = {m_st == INTRO, m_st == PLAY, m_rs, (m_st == WIN) || (m_st == LOSE), m_st == WIN};
      got_f = {bus.show_banner, bus.play_active, bus.round_start, bus.game_over, bus.game_won};
      checks++; if (bus.state_o !== m_st) begin errors++; $display("FAIL rnd_state cyc=%0d got=%0d exp=%0d", i, bus.state_o, m_st); end
      checks++; if (bus.round_o !== 4'(m_round)) begin errors++; $display("FAIL rnd_round cyc=%0d got=%0d exp=%0d", i, bus.round_o, m_round); end
      checks++; if (bus.time_left !== 12'(m_time)) begin errors++; $display("FAIL rnd_time cyc=%0d got=%0d exp=%0d", i, bus.time_left, m_time); end
      checks++; if (bus.score !== 16'(m_score)) begin errors++; $display("FAIL rnd_score cyc=%0d got=%0d exp=%0d", i, bus.score, m_score); end
      checks++; if (got_f !== exp_f) begin errors++; $display("FAIL rnd_flags cyc=%0d got=%b exp=%b", i, got_f, exp_f); end
    end
  endtask

  initial begin
    RESET = 1'b1;
    bus.start = 0; bus.frame_tick = 0; bus.pause_req = 0; bus.round_clear = 0; bus.player_dead = 0;
    test_reset();
    test_first_round();
    test_round_clear();
    test_win();
    test_timeout();
    test_pause();
    test_reset_mid_play();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
